// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix-vector sequencer: controller state
// encoding, datapath word widths and a width helper for address ports.
package matrix_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Datapath widths. The multiplier consumes bits [15:3] of each 16-bit
    // memory word, so the operand is 13 bits wide.
    localparam int DATA_W = 16;
    localparam int OPND_W = 13;
    localparam int PROD_W = 17;
    localparam int ACC_W  = 20;

    // $clog2 that never returns 0. A degenerate dimension of 1 still gets a
    // one-bit address port instead of a zero-width vector.
    function automatic int clog2_min1(input int value);
        if (value <= 1) begin
            return 1;
        end
        return $clog2(value);
    endfunction

endpackage

// File: rtl/seq_align_pipe.sv
// Fixed-depth shift register that delays the "first column issued" flag so
// that it reaches the datapath together with the first product of a row.
// Cleared by reset and by a synchronous clear (abort).
module seq_align_pipe
    import matrix_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic in_flag,
    output logic out_flag
);

    logic [DEPTH-1:0] stages;

    // Shift the flag one stage per clock; the oldest stage drives the output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stages <= '0;
        end else if (clear) begin
            stages <= '0;
        end else begin
            stages[0] <= in_flag;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign out_flag = stages[DEPTH-1];

endmodule

// File: rtl/matrix_sequencer.sv
// Controller for the shared multiply-accumulate datapath computing
// ai = W * Xt one row at a time. For each row it streams the weight row and
// the input vector out of two read-latency-1 memories, aligns
// start_accumulate with the row's first product, waits for the pipeline to
// drain and captures ai into a valid/ready result register.
//
// Build option: define MATRIX_SEQ_ABORT_EN to add the 'abort' input, which
// returns the controller to IDLE from any state with all outputs cleared.
module matrix_sequencer
    import matrix_pkg::*;
#(
    parameter int N_ROWS    = 16,
    parameter int N_COLS    = 16,
    parameter int MAC_LAT   = 1,
    parameter int DRAIN_LAT = 2
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
`ifdef MATRIX_SEQ_ABORT_EN
    input  logic                                   abort,
`endif
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   w_rd_en,
    output logic [clog2_min1(N_ROWS*N_COLS)-1:0]   w_addr,
    output logic                                   x_rd_en,
    output logic [clog2_min1(N_COLS)-1:0]          x_addr,
    output logic                                   start_accumulate,
    input  logic [ACC_W-1:0]                       ai,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ACC_W-1:0]                       out_data,
    output logic [clog2_min1(N_ROWS)-1:0]          out_row
);

    localparam int W_AW = clog2_min1(N_ROWS * N_COLS);
    localparam int X_AW = clog2_min1(N_COLS);
    localparam int R_AW = clog2_min1(N_ROWS);

    // After the last issue the pipeline needs one memory cycle, MAC_LAT
    // multiplier cycles and DRAIN_LAT accumulator cycles; the capture itself
    // happens in the cycle after that count.
    localparam int DRAIN_CYC = 1 + MAC_LAT + DRAIN_LAT;
    localparam int D_W       = clog2_min1(DRAIN_CYC + 1);

    localparam logic [X_AW-1:0] COL_LAST  = X_AW'(N_COLS - 1);
    localparam logic [R_AW-1:0] ROW_LAST  = R_AW'(N_ROWS - 1);
    localparam logic [D_W-1:0]  DRAIN_END = D_W'(DRAIN_CYC);

    seq_state_t      state;
    seq_state_t      state_next;

    logic [X_AW-1:0] col;
    logic [R_AW-1:0] row;
    logic [D_W-1:0]  drain_cnt;

    // Per-cycle control strobes decoded from the state.
    logic            run_start;
    logic            issue;
    logic            capture;
    logic            done_set;

    logic            handshake;
    logic            last_col;
    logic            last_row;
    logic            drain_end;
    logic            issue_first;
    logic            abort_req;

    assign handshake   = out_valid && out_ready;
    assign last_col    = (col == COL_LAST);
    assign last_row    = (row == ROW_LAST);
    assign drain_end   = (drain_cnt == DRAIN_END);
    assign issue_first = issue && (col == '0);

`ifdef MATRIX_SEQ_ABORT_EN
    assign abort_req = abort && (state != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // always_ff reading it in the same edge sees the pre-edge value.
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and control strobes; abort overrides everything.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a
        // path through the case that skips it would infer a latch.
        state_next = state;
        run_start  = 1'b0;
        issue      = 1'b0;
        capture    = 1'b0;
        done_set   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    run_start  = 1'b1;
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                issue = 1'b1;
                if (last_col) begin
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                if (drain_end) begin
                    // The result register can take ai now only if it is empty
                    // or its current contents leave this very cycle.
                    if (!out_valid || handshake) begin
                        capture    = 1'b1;
                        state_next = last_row ? DONE : ISSUE;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end

            HOLD: begin
                // Nothing issues while waiting, so ai is still this row's sum.
                if (handshake) begin
                    capture    = 1'b1;
                    state_next = last_row ? DONE : ISSUE;
                end
            end

            DONE: begin
                if (!out_valid || handshake) begin
                    done_set   = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort_req) begin
            state_next = IDLE;
            run_start  = 1'b0;
            issue      = 1'b0;
            capture    = 1'b0;
            done_set   = 1'b0;
        end
    end

    // Address counters, drain timer, result register and done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col       <= '0;
            row       <= '0;
            w_addr    <= '0;
            drain_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            done      <= 1'b0;
        end else if (abort_req) begin
            col       <= '0;
            row       <= '0;
            w_addr    <= '0;
            drain_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            done      <= 1'b0;
        end else begin
            done <= done_set;

            if (run_start) begin
                col    <= '0;
                row    <= '0;
                w_addr <= '0;
            end

            if (issue) begin
                col <= last_col ? '0 : col + 1'b1;
                // The weight address runs straight through all rows and
                // parks on the final word instead of wrapping.
                if (!(last_col && last_row)) begin
                    w_addr <= w_addr + 1'b1;
                end
            end

            if (state == DRAIN && !drain_end) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end

            // A capture in a handshake cycle refills the register, so
            // out_valid only falls when it is consumed without a refill.
            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= ai;
                out_row   <= row;
                if (!last_row) begin
                    row <= row + 1'b1;
                end
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign w_rd_en = issue;
    assign x_rd_en = issue;
    assign x_addr  = col;

    // Delays the first-column issue by the memory read cycle plus the
    // multiplier latency, landing on the first product of the row.
    seq_align_pipe #(
        .DEPTH (1 + MAC_LAT)
    ) u_align (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (abort_req),
        .in_flag  (issue_first),
        .out_flag (start_accumulate)
    );

endmodule

// File: tb/tb_matrix_sequencer.sv
// Self-checking bench for matrix_sequencer on a 2x4 matrix. The bench models
// the two memories and the MAC datapath around the DUT; expected row results
// come from a plain sum-of-products over the memory contents.
// Define MATRIX_SEQ_ABORT_EN to also exercise the abort input.
module tb_matrix_sequencer;

    localparam int N_ROWS     = 2;
    localparam int N_COLS     = 4;
    localparam int MAC_LAT    = 1;
    localparam int DRAIN_LAT  = 2;
    localparam int W_DEPTH    = N_ROWS * N_COLS;
    localparam int ROW_PERIOD = N_COLS + 1 + MAC_LAT + DRAIN_LAT + 1;
    localparam int BUDGET     = 400;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, w_rd_en, x_rd_en, start_accumulate, out_valid;
    logic [2:0]  w_addr;
    logic [1:0]  x_addr;
    logic [19:0] ai;
    logic [19:0] out_data;
    logic        out_row;
`ifdef MATRIX_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif

    matrix_sequencer #(
        .N_ROWS    (N_ROWS),
        .N_COLS    (N_COLS),
        .MAC_LAT   (MAC_LAT),
        .DRAIN_LAT (DRAIN_LAT)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
`ifdef MATRIX_SEQ_ABORT_EN
        .abort            (abort),
`endif
        .start            (start),
        .busy             (busy),
        .done             (done),
        .w_rd_en          (w_rd_en),
        .w_addr           (w_addr),
        .x_rd_en          (x_rd_en),
        .x_addr           (x_addr),
        .start_accumulate (start_accumulate),
        .ai               (ai),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_row          (out_row)
    );

    always #5 clock = ~clock;

    // ---------------- environment: memories and MAC datapath ----------------
    logic [15:0] w_mem [W_DEPTH];
    logic [15:0] x_mem [N_COLS];

    logic [15:0] w_q    = '0;
    logic [15:0] x_q    = '0;
    logic        mem_v  = 1'b0;
    logic        prod_v = 1'b0;
    logic [16:0] prod   = '0;
    logic [19:0] acc    = '0;
    logic [19:0] ai_q   = '0;

    function automatic logic [16:0] trunc_mul(input logic [12:0] a, input logic [12:0] b);
        logic [25:0] p;
        p = a * b;
        return p[16:0];
    endfunction

    // One read cycle, one multiplier stage (MAC_LAT=1), then accumulator and
    // result register (DRAIN_LAT=2).
    always @(posedge clock) begin
        mem_v <= w_rd_en;
        if (w_rd_en) begin
            w_q <= w_mem[w_addr];
            x_q <= x_mem[x_addr];
        end
        prod_v <= mem_v;
        prod   <= trunc_mul(w_q[15:3], x_q[15:3]);
        if (prod_v) begin
            acc <= start_accumulate ? {3'b000, prod} : acc + {3'b000, prod};
        end
        ai_q <= acc;
    end
    assign ai = ai_q;

    // Row result from the matrix contents: 13-bit operands, products kept to
    // 17 bits, sum kept to 20 bits.
    function automatic logic [19:0] ref_row(input int r);
        longint s;
        longint p;
        s = 0;
        for (int c = 0; c < N_COLS; c++) begin
            p = ((longint'(w_mem[r*N_COLS + c]) >> 3) * (longint'(x_mem[c]) >> 3)) % 131072;
            s = (s + p) % 1048576;
        end
        return s[19:0];
    endfunction

    // ---------------- scoring ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          issue_cnt, addr_bad, sa_cnt, sa_bad, done_cnt, stable_bad, last_col0;
    int          col0_q[$];
    logic [19:0] res_data[$];
    int          res_row[$];
    logic        prev_hold = 1'b0;
    logic [19:0] prev_data = '0;
    logic        prev_row  = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (w_rd_en !== x_rd_en) addr_bad++;
        if (w_rd_en) begin
            if (int'(w_addr) != issue_cnt || int'(x_addr) != issue_cnt % N_COLS) addr_bad++;
            if (x_addr == 2'd0) begin
                last_col0 = cyc;
                col0_q.push_back(cyc);
            end
            issue_cnt++;
        end
        if (start_accumulate) begin
            sa_cnt++;
            if (cyc - last_col0 != 1 + MAC_LAT) sa_bad++;
        end
        if (prev_hold && !(out_valid && out_data == prev_data && out_row == prev_row)) stable_bad++;
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_row  = out_row;
        if (out_valid && out_ready) begin
            res_data.push_back(out_data);
            res_row.push_back(int'(out_row));
        end
        if (done) done_cnt++;
    end

    task automatic clear_mon();
        issue_cnt  = 0;
        addr_bad   = 0;
        sa_cnt     = 0;
        sa_bad     = 0;
        done_cnt   = 0;
        stable_bad = 0;
        last_col0  = -100;
        prev_hold  = 1'b0;
        col0_q.delete();
        res_data.delete();
        res_row.delete();
    endtask

    task automatic fill_const(input logic [15:0] wv, input logic [15:0] xv);
        for (int i = 0; i < W_DEPTH; i++) w_mem[i] = wv;
        for (int i = 0; i < N_COLS; i++) x_mem[i] = xv;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < W_DEPTH; i++) w_mem[i] = 16'($urandom);
        for (int i = 0; i < N_COLS; i++) x_mem[i] = 16'($urandom);
    endtask

    // One complete run. stall: cycles out_ready stays low from the first
    // out_valid; rnd_ready: random out_ready every cycle; restart_at: cycle
    // at which a stray start is pulsed mid-run (-1 for none).
    task automatic do_run(input string tag, input int stall, input bit rnd_ready, input int restart_at);
        int k;
        int first_k;
        logic [19:0] exp_row [N_ROWS];
        for (int r = 0; r < N_ROWS; r++) exp_row[r] = ref_row(r);
        clear_mon();
        out_ready = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        k = 0;
        first_k = -1;
        while (done_cnt == 0 && k < BUDGET) begin
            @(posedge clock);
            #1;
            k++;
            start = (k == restart_at);
            if (out_valid && first_k < 0) first_k = k;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            else if (first_k >= 0) out_ready = (k >= first_k + stall);
        end
        start = 1'b0;
        check({tag, "/done_seen"}, done_cnt > 0, 1);
        repeat (5) @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({tag, "/done_once"}, done_cnt, 1);
        check({tag, "/idle_after"}, {busy, out_valid}, 2'b00);
        check({tag, "/first_valid_latency"}, first_k, ROW_PERIOD);
        check({tag, "/rows_out"}, res_data.size(), N_ROWS);
        for (int r = 0; r < N_ROWS && r < res_data.size(); r++) begin
            check($sformatf("%s/row%0d_data", tag, r), res_data[r], exp_row[r]);
            check($sformatf("%s/row%0d_index", tag, r), res_row[r], r);
        end
        check({tag, "/issue_count"}, issue_cnt, W_DEPTH);
        check({tag, "/addr_seq"}, addr_bad, 0);
        check({tag, "/start_acc_pulses"}, sa_cnt, N_ROWS);
        check({tag, "/start_acc_align"}, sa_bad, 0);
        check({tag, "/hold_stable"}, stable_bad, 0);
        if (!rnd_ready && stall == 0 && col0_q.size() >= 2) begin
            check({tag, "/row_period"}, col0_q[1] - col0_q[0], ROW_PERIOD);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        string       name;
        logic [15:0] w_val;
        logic [15:0] x_val;
        int          stall;
        int          restart;
        logic [19:0] exp_ai;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"unit",     16'h0008, 16'h0008,  0, -1, 20'd4};
        vecs[1] = '{"stall10",  16'h0008, 16'h0008, 10, -1, 20'd4};
        vecs[2] = '{"restart",  16'h0010, 16'h0018,  3,  3, 20'd24};
        vecs[3] = '{"lowbits",  16'h0007, 16'hFFFF,  0, -1, 20'd0};
        vecs[4] = '{"max_w",    16'hFFF8, 16'h0008,  0,  6, 20'd32764};
        vecs[5] = '{"carry",    16'h0400, 16'h0400,  5, -1, 20'h10000};

        clear_mon();
        #12;
        check("reset_outputs", {busy, done, w_rd_en, x_rd_en, start_accumulate, out_valid,
                                w_addr, x_addr, out_data, out_row}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("idle_busy", busy, 1'b0);

        for (int v = 0; v < 6; v++) begin
            fill_const(vecs[v].w_val, vecs[v].x_val);
            do_run(vecs[v].name, vecs[v].stall, 1'b0, vecs[v].restart);
            for (int r = 0; r < N_ROWS && r < res_data.size(); r++) begin
                check($sformatf("%s/table_row%0d", vecs[v].name, r), res_data[r], vecs[v].exp_ai);
            end
        end

        // Reset asserted while issuing row 0.
        fill_const(16'h0008, 16'h0008);
        clear_mon();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        check("midreset/issuing", {busy, w_rd_en, x_addr}, {1'b1, 1'b1, 2'd1});
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset/outputs", {busy, done, w_rd_en, x_rd_en, start_accumulate, out_valid,
                                   w_addr, x_addr, out_data, out_row}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        do_run("after_reset", 0, 1'b0, -1);

        // Random contents with random back-pressure.
        for (int t = 0; t < 4; t++) begin
            fill_rand();
            do_run($sformatf("rand%0d", t), 0, 1'b1, -1);
        end

`ifdef MATRIX_SEQ_ABORT_EN
        // Abort while draining row 1 with row 0 still held in the output.
        fill_const(16'h0008, 16'h0008);
        clear_mon();
        out_ready = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        check("abort/before", {busy, out_valid, w_rd_en}, 3'b110);
        abort = 1'b1;
        @(posedge clock);
        #1;
        abort = 1'b0;
        check("abort/after", {busy, done, w_rd_en, start_accumulate, out_valid,
                              w_addr, x_addr, out_data, out_row}, 31'h0);
        repeat (30) @(posedge clock);
        #1;
        check("abort/no_done", done_cnt, 0);
        check("abort/still_idle", busy, 1'b0);
        do_run("after_abort", 0, 1'b0, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_sequencer.md
# matrix_sequencer

Controller that sequences the shared multiply-accumulate datapath (multiplier → accumulator → result register) through a matrix-vector product `ai = W·Xt`. It reads one weight row and the input vector from synchronous-read memories, aligns `start_accumulate` with the first product of each row, and captures each row's `ai` after the pipeline drains. It then presents the result on a valid/ready output. It sits between the gate-weight/input buffers and the tanh stage.

## Interface

- `N_ROWS`, 16: rows of W (outputs per run).
- `N_COLS`, 16: columns of W (vector length), ≥ 1.
- `MAC_LAT`, 1: cycles from operand presentation at the datapath inputs to the product reaching the accumulator.
- `DRAIN_LAT`, 2: cycles from the last product entering the accumulator to final `ai` being valid.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle run request; ignored unless IDLE.
- `busy` out 1: high from the accepted `start` to the `done` pulse.
- `done` out 1: one-cycle pulse after the last row is accepted downstream.
- `w_rd_en` out 1: weight memory read enable.
- `w_addr` out `$clog2(N_ROWS*N_COLS)`: weight address = row·N_COLS + col.
- `x_rd_en` out 1: input memory read enable.
- `x_addr` out `$clog2(N_COLS)`: input address = col.
- `start_accumulate` out 1: to datapath, high for the first product of each row.
- `ai` in 20: datapath result.
- `out_valid` out 1: result register holds an unconsumed row result.
- `out_ready` in 1: downstream accepts on `out_valid & out_ready`.
- `out_data` out 20: captured `ai`.
- `out_row` out `$clog2(N_ROWS)`: row index of `out_data`.

## Operation

- States: IDLE, ISSUE, DRAIN, HOLD, DONE.
- IDLE: `start` → ISSUE, row=0, col=0, `busy`=1.
- ISSUE: each cycle assert `w_rd_en`/`x_rd_en` with current addresses; col increments; after col = N_COLS−1 → DRAIN. Memories return data one cycle after address (fixed read latency 1).
- `start_accumulate` = issue-of-col-0 flag delayed by 1 + MAC_LAT cycles; exactly one cycle high per row.
- DRAIN: count 1 + MAC_LAT + DRAIN_LAT cycles after last issue, then capture `ai`:
  - if output register empty, or being consumed this cycle → capture, then ISSUE for next row (or DONE after row N_ROWS−1);
  - otherwise → HOLD.
- HOLD: wait for `out_ready`. On handshake, capture `ai` the same cycle; `ai` is stable because no new row issues. Then proceed as from DRAIN.
- DONE: wait until the output register is consumed, pulse `done`, → IDLE.
- Rows never overlap in the datapath. The next row's issue starts the cycle after capture.
- `out_valid` drops on handshake unless a new capture occurs in the same cycle.
- `start` while not IDLE: ignored, no error.
- Address counters never wrap within a run; they reset to 0 at each `start`.

## Timing

- Reset (async assert, synchronous-release expected upstream): state=IDLE; `busy`, `done`, `w_rd_en`, `x_rd_en`, `start_accumulate`, `out_valid` = 0; `w_addr`, `x_addr`, `out_data`, `out_row` = 0.
- Reset mid-run discards everything; the datapath state is don't-care until the next `start_accumulate`.
- First `w_rd_en` appears the cycle after `start`.
- Row period without back-pressure = N_COLS + 1 + MAC_LAT + DRAIN_LAT + 1 cycles.
- Defaults (16×16) give 21 cycles per row.
- First `out_valid` occurs 21 cycles after `start`.

## Configuration

- `MATRIX_SEQ_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort` high in any non-IDLE state → next cycle IDLE.
  - All outputs take their reset values; no `done` pulse.
  - `abort` has priority over `start` and the handshake.
- Undefined: no `abort` port; a run always completes.

## Structure

- Shared `matrix_pkg`:
  - state enum `seq_state_t`;
  - `DATA_W`=16, `OPND_W`=13 (datapath uses bits [15:3]), `PROD_W`=17, `ACC_W`=20.
- Sub-module `seq_align_pipe`: parameterised-depth shift register producing `start_accumulate` from the issue flag; reset to 0.

## Test plan

- N_ROWS=2, N_COLS=4, all weights and inputs 16'h0008, `out_ready`=1 → `out_data`=4 for rows 0 and 1; `done` exactly once; `w_addr` sequence 0..7.
- Same run, `out_ready` held 0 for 10 cycles after first `out_valid` → state HOLD; row 0 value stays stable; row 1 equals 4; no datapath issue during HOLD.
- Check `start_accumulate` → one pulse per row, exactly 1+MAC_LAT cycles after the `x_addr`=0 issue.
- `start` pulsed during a run → ignored; addresses unaffected.
- `reset_n` low mid-ISSUE → all outputs at reset values immediately; new `start` produces correct results.
- With `MATRIX_SEQ_ABORT_EN`, `abort` in DRAIN → IDLE next cycle; `out_valid`=0; no `done`.
